// File: rtl/seg7_pkg.sv
// Shared segment encodings, FSM state type and double-dabble helper for the
// BCD display driver.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    // Double-dabble pre-shift correction for one BCD nibble.
    function automatic logic [3:0] dd_adj(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// BCD nibble to active-low 7-segment pattern; non-decimal codes show blank so
// they can never be mistaken for a zero digit.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0: o_seg = SEG_0;
            4'd1: o_seg = SEG_1;
            4'd2: o_seg = SEG_2;
            4'd3: o_seg = SEG_3;
            4'd4: o_seg = SEG_4;
            4'd5: o_seg = SEG_5;
            4'd6: o_seg = SEG_6;
            4'd7: o_seg = SEG_7;
            4'd8: o_seg = SEG_8;
            4'd9: o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_display_driver.sv
// Sequential binary to 3-digit + sign 7-segment driver; one double-dabble
// iteration per clock, outputs held until the next conversion completes.
module bcd_display_driver
    import seg7_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIGITS = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] result,
    input  logic              signed_mode,
    output logic              busy,
    output logic              done,
    output logic [6:0]        HEX0,
    output logic [6:0]        HEX1,
    output logic [6:0]        HEX2,
    output logic [6:0]        HEX3
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);

    state_t                   r_state;
    state_t                   w_next;
    logic                     w_load;
    logic                     w_shift;
    logic                     w_update;

    logic [DATA_W-1:0]        r_mag;
    logic [BCD_W-1:0]         r_bcd;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_neg;
    logic                     r_busy;
    logic                     r_done;
    logic [6:0]               r_hex0, r_hex1, r_hex2, r_hex3;

    logic [BCD_W-2:0]         w_bcd_adj;
    logic [DIGITS-1:0][6:0]   w_seg;
    logic                     w_is_neg;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next = ST_CONV;
            ST_CONV:   if (r_cnt == CNT_W'(1)) w_next = ST_UPDATE;
            ST_UPDATE: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_load   = 1'b0;
        w_shift  = 1'b0;
        w_update = 1'b0;
        case (r_state)
            ST_IDLE:   w_load   = start;
            ST_CONV:   w_shift  = 1'b1;
            ST_UPDATE: w_update = 1'b1;
            default:   ;
        endcase
    end

    // ---------------- double-dabble datapath ----------------
    // The top digit is at most 2 before the final shift for any legal width,
    // so it never needs the +3 correction and its MSB is never shifted out.
    genvar d;
    generate
        for (d = 0; d < DIGITS - 1; d++) begin : g_adj
            assign w_bcd_adj[4*d +: 4] = dd_adj(r_bcd[4*d +: 4]);
        end
    endgenerate
    assign w_bcd_adj[BCD_W-2 -: 3] = r_bcd[BCD_W-2 -: 3];

    assign w_is_neg = signed_mode & result[DATA_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mag <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
            r_neg <= 1'b0;
        end else if (w_load) begin
            r_mag <= w_is_neg ? (~result + DATA_W'(1)) : result;
            r_bcd <= '0;
            r_cnt <= CNT_W'(DATA_W);
            r_neg <= w_is_neg;
        end else if (w_shift) begin
            {r_bcd, r_mag} <= {w_bcd_adj, r_mag, 1'b0};
            r_cnt          <= r_cnt - CNT_W'(1);
        end
    end

    // ---------------- decode and output registers ----------------
    generate
        for (d = 0; d < DIGITS; d++) begin : g_dec
            seg7_decoder u_dec (
                .i_bcd (r_bcd[4*d +: 4]),
                .o_seg (w_seg[d])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_hex0 <= SEG_BLANK;
            r_hex1 <= SEG_BLANK;
            r_hex2 <= SEG_BLANK;
            r_hex3 <= SEG_BLANK;
        end else begin
            r_busy <= (w_next != ST_IDLE);
            r_done <= w_update;
            if (w_update) begin
                r_hex0 <= w_seg[0];
                r_hex1 <= w_seg[1];
                r_hex2 <= w_seg[2];
                r_hex3 <= r_neg ? SEG_MINUS : SEG_BLANK;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign HEX0 = r_hex0;
    assign HEX1 = r_hex1;
    assign HEX2 = r_hex2;
    assign HEX3 = r_hex3;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Directed bench for bcd_display_driver: latency, busy window, decoded digits,
// handshake corner cases and asynchronous reset.
module tb_bcd_display_driver;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] result;
    logic       signed_mode;
    logic       busy;
    logic       done;
    logic [6:0] HEX0, HEX1, HEX2, HEX3;

    int n_chk  = 0;
    int n_pass = 0;

    bcd_display_driver #(.DATA_W(8), .DIGITS(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .result      (result),
        .signed_mode (signed_mode),
        .busy        (busy),
        .done        (done),
        .HEX0        (HEX0),
        .HEX1        (HEX1),
        .HEX2        (HEX2),
        .HEX3        (HEX3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [27:0] hex_all();
        return {HEX3, HEX2, HEX1, HEX0};
    endfunction

    // Leaves the bench #1 after the accepting edge with start low again.
    task automatic start_conv(input logic [7:0] res, input logic sm);
        result      = res;
        signed_mode = sm;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start       = 1'b0;
    endtask

    // Counts edges until done, bounded; lat = 0 means it never came.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = int'(busy);
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                return;
            end
            bcnt += int'(busy);
        end
    endtask

    int lat, bc, ndone;

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        result      = '0;
        signed_mode = 1'b0;

        #12;
        chk("rst_hex",  hex_all(), {7'h7F, 7'h7F, 7'h7F, 7'h7F});
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // unsigned zero
        start_conv(8'h00, 1'b0);
        wait_done(lat, bc);
        chk("zero_lat",      lat, 9);
        chk("zero_busy_cnt", bc, 9);
        chk("zero_busy_end", busy, 0);
        chk("zero_hex",      hex_all(), {7'h7F, 7'h40, 7'h40, 7'h40});
        @(posedge clk); #1;
        chk("zero_done_pulse", done, 0);
        chk("zero_hold",       hex_all(), {7'h7F, 7'h40, 7'h40, 7'h40});
        @(negedge clk);

        // unsigned max
        start_conv(8'hFF, 1'b0);
        wait_done(lat, bc);
        chk("u255_lat", lat, 9);
        chk("u255_hex", hex_all(), {7'h7F, 7'h24, 7'h12, 7'h12});
        @(negedge clk);

        // signed -128
        start_conv(8'h80, 1'b1);
        wait_done(lat, bc);
        chk("s128_lat", lat, 9);
        chk("s128_hex", hex_all(), {7'h3F, 7'h79, 7'h24, 7'h00});
        @(negedge clk);

        // signed -1, then back-to-back start in the done cycle with +127
        start_conv(8'hFF, 1'b1);
        wait_done(lat, bc);
        chk("s1_lat", lat, 9);
        chk("s1_hex", hex_all(), {7'h3F, 7'h40, 7'h40, 7'h79});
        chk("b2b_done_at_start", done, 1);
        start_conv(8'h7F, 1'b1);
        chk("b2b_busy", busy, 1);
        wait_done(lat, bc);
        chk("b2b_lat", lat, 9);
        chk("b2b_hex", hex_all(), {7'h7F, 7'h79, 7'h24, 7'h78});
        @(negedge clk);

        // start while busy is ignored, not queued
        start_conv(8'h07, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        result = 8'h05;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        result = 8'hAA;
        wait_done(lat, bc);
        chk("ign_lat", (lat == 0) ? 0 : lat + 3, 9);
        chk("ign_hex", hex_all(), {7'h7F, 7'h40, 7'h40, 7'h78});
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            ndone += int'(done);
        end
        chk("ign_no_requeue", ndone, 0);
        @(negedge clk);

        // reset during CONV iteration 4
        start_conv(8'h2A, 1'b0);
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_hex",  hex_all(), {7'h7F, 7'h7F, 7'h7F, 7'h7F});
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 2) begin
                @(negedge clk);
                rst_n = 1'b1;
            end
            @(posedge clk); #1;
            ndone += int'(done);
        end
        chk("mid_rst_no_done", ndone, 0);
        chk("mid_rst_blank",   hex_all(), {7'h7F, 7'h7F, 7'h7F, 7'h7F});
        @(negedge clk);

        start_conv(8'h2A, 1'b0);
        wait_done(lat, bc);
        chk("post_rst_lat", lat, 9);
        chk("post_rst_hex", hex_all(), {7'h7F, 7'h40, 7'h19, 7'h24});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
